apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
- APB completer (responder) for one of the three Pselx lines driven by the AHB-to-APB bridge.
- Provides a word-addressed register bank, read data aligned to the bridge's zero-wait-state timing, and read/write transaction counters.
- Includes a protocol checker that flags and blocks malformed SETUP/ACCESS sequences.
- Used as the bridge's APB-side peripheral in the testbench and in the SoC integration.

Parameters:
- SEL_INDEX, 0, which bit of Pselx selects this slave (0..2).
- DEPTH, 16, number of 32-bit registers (power of 2, 2..256).
- CNT_W, 16, width of the transaction and error counters.

Ports:
- Hclk  input  1  system clock; all logic on the rising edge.
- Hreset  input  1  synchronous reset, active-high.
- Pselx  input  3  APB select vector from the bridge; only bit SEL_INDEX is used.
- Penable  input  1  APB access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; index = Paddr[2 +: log2(DEPTH)]; other bits ignored (aliasing).
- Pwdata  input  32  write data.
- Prdata  output  32  read data back to the bridge.
- err_clr  input  1  single-cycle pulse that clears prot_err.
- prot_err  output  1  sticky flag for a protocol violation.
- wr_cnt  output  CNT_W  number of committed writes; wraps.
- rd_cnt  output  CNT_W  number of committed reads; wraps.
- err_cnt  output  CNT_W  number of violations; saturates at all-ones.

Behaviour:
- Reset (Hreset=1 at a clock edge): FSM goes to IDLE; all registers, Prdata, counters and prot_err go to 0. Reset during SETUP or ACCESS abandons the transfer with no commit.
- sel = Pselx[SEL_INDEX].
- FSM states: IDLE, SETUP, ACCESS. No wait states; ACCESS lasts exactly 1 cycle.
- IDLE:
  - sel & !Penable: latch Paddr index and Pwrite; go to SETUP.
  - sel & Penable: violation (access without setup); stay in IDLE.
  - otherwise: stay in IDLE.
- SETUP:
  - sel & Penable with index and Pwrite unchanged from the latched values: go to ACCESS. The transfer commits on this edge.
  - sel & Penable with a changed index or Pwrite: violation, no commit; go to IDLE.
  - !sel, or sel & !Penable: violation; go to IDLE.
- ACCESS:
  - sel & !Penable: back-to-back transfer; latch the new index and Pwrite; go to SETUP.
  - !sel: go to IDLE.
  - sel & Penable: violation (extended access is not supported); go to IDLE with no second commit.
- Write commit (SETUP to ACCESS edge, Pwrite=1): reg[index] <= Pwdata; wr_cnt += 1.
- Read:
  - On the edge that enters SETUP with Pwrite=0, Prdata <= reg[index]. Prdata is therefore valid throughout the ACCESS cycle, as the bridge requires.
  - rd_cnt += 1 at commit.
  - Prdata holds its value until the next read SETUP. Writes never change Prdata, even a write to the same index.
- Violation: prot_err <= 1; err_cnt += 1 (saturating).
- err_clr in the same cycle as a violation: the violation wins and prot_err stays 1.
- Counters: wr_cnt and rd_cnt wrap modulo 2^CNT_W; err_cnt saturates.
- Unselected activity (sel=0) has no side effects, except the ACCESS-to-IDLE transition above.

Decomposition:
- Package apb_slave_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - ADDR_LSB = 2;
  - function idx_w(DEPTH) = clog2(DEPTH).
- One sub-module, apb_protocol_checker:
  - contains the FSM, the latched index/Pwrite, and the violation detection;
  - outputs wr_commit, rd_setup, rd_commit, violation.
- The top level holds the register array, Prdata, the counters and prot_err.

Test Plan:
- Write then read: write Paddr=0x8000_0008, Pwdata=0xDEAD_BEEF, then read the same address → Prdata=0xDEAD_BEEF during ACCESS; wr_cnt=1, rd_cnt=1; prot_err=0.
- Back-to-back: write index 3 (0x11), then write index 4 (0x22) with ACCESS→SETUP directly, then read both → 0x11 and 0x22; wr_cnt=2, rd_cnt=2; no violation.
- Access without setup: in IDLE, sel=1 & Penable=1 with Pwrite=1, Pwdata=0x55 → reg unchanged, prot_err=1, err_cnt=1. Then pulse err_clr → prot_err=0 and err_cnt stays 1.
- Address change mid-transfer: SETUP at index 2, ACCESS at index 5 with Pwrite=1 → no write to either index; prot_err=1; FSM returns to IDLE, and a following legal write succeeds.
- Aliasing and deselect: with DEPTH=16, write Paddr=0x40 (index 0) = 0xA5A5_A5A5 and read Paddr=0x00 → 0xA5A5_A5A5. Transfers on Pselx bits ≠ SEL_INDEX → no change to counters or registers.
- Reset mid-write: assert Hreset in the SETUP cycle of a write → all registers 0, wr_cnt=0, FSM in IDLE, no commit. err_clr asserted together with a violation → prot_err stays 1.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-bank slave.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Paddr is a byte address; registers are 32-bit words.
  localparam int ADDR_LSB = 2;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus signals between the bridge (master) and this slave.
interface apb_slave_regbank_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_protocol_checker.sv
// APB SETUP/ACCESS sequencer: tracks the transfer, latches index/direction
// at SETUP and flags any malformed phase sequence.
module apb_protocol_checker
  import apb_slave_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] xfer_idx,
  output logic             wr_commit,
  output logic             rd_setup,
  output logic             rd_commit,
  output logic             violation
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;

  assign xfer_idx = idx_q;

  // State, latched index and direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Next state, commit strobes and violation detection.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wr_commit = 1'b0;
    rd_setup  = 1'b0;
    rd_commit = 1'b0;
    violation = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !penable) begin
          idx_d    = idx;
          wr_d     = pwrite;
          rd_setup = !pwrite;
          state_d  = SETUP;
        end else if (sel && penable) begin
          violation = 1'b1;  // access without setup
        end
      end
      SETUP: begin
        if (sel && penable && (idx == idx_q) && (pwrite == wr_q)) begin
          wr_commit = wr_q;
          rd_commit = !wr_q;
          state_d   = ACCESS;
        end else begin
          // deselect, missing enable, or address/direction changed
          violation = 1'b1;
          state_d   = IDLE;
        end
      end
      ACCESS: begin
        if (sel && !penable) begin
          idx_d    = idx;
          wr_d     = pwrite;
          rd_setup = !pwrite;
          state_d  = SETUP;
        end else if (!sel) begin
          state_d = IDLE;
        end else begin
          violation = 1'b1;  // extended access has no wait-state support
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with read/write/violation counters and a sticky
// protocol-error flag. Read data is fetched at SETUP so it is stable for the
// whole zero-wait ACCESS cycle.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int SEL_INDEX = 0,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_slave_regbank_if.slave bus,
  input  logic             err_clr,
  output logic             prot_err,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IDX_W = idx_w(DEPTH);

  logic             sel;
  logic [IDX_W-1:0] idx, xfer_idx;
  logic             wr_commit, rd_setup, rd_commit, violation;

  logic [DEPTH-1:0][31:0] regs_q, regs_d;
  logic [31:0]            prdata_q, prdata_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic                   prot_err_q, prot_err_d;

  // Upper address bits alias; other select lines belong to sibling slaves.
  logic unused_ok;
  assign unused_ok = ^{bus.Paddr, bus.Pselx};

  assign sel = bus.Pselx[SEL_INDEX];
  assign idx = bus.Paddr[ADDR_LSB +: IDX_W];

  apb_protocol_checker #(.IDX_W(IDX_W)) u_chk (
    .clk       (Hclk),
    .rst       (Hreset),
    .sel       (sel),
    .penable   (bus.Penable),
    .pwrite    (bus.Pwrite),
    .idx       (idx),
    .xfer_idx  (xfer_idx),
    .wr_commit (wr_commit),
    .rd_setup  (rd_setup),
    .rd_commit (rd_commit),
    .violation (violation)
  );

  // Register writes, read fetch, counters and error flag.
  always_comb begin
    regs_d     = regs_q;
    prdata_d   = prdata_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_cnt_d  = err_cnt_q;
    prot_err_d = prot_err_q;
    if (wr_commit) begin
      regs_d[xfer_idx] = bus.Pwdata;
      wr_cnt_d         = wr_cnt_q + 1'b1;
    end
    if (rd_setup)  prdata_d = regs_q[idx];
    if (rd_commit) rd_cnt_d = rd_cnt_q + 1'b1;
    // a violation in the same cycle as err_clr keeps the flag set
    if (violation) begin
      prot_err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end else if (err_clr) begin
      prot_err_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      regs_q     <= '0;
      prdata_q   <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
      prot_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      prdata_q   <= prdata_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign bus.Prdata = prdata_q;
  assign prot_err   = prot_err_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: read data is checked by a monitor
// against a queue of expected values; counters and flags are checked inline.
module tb_apb_slave_regbank;

  localparam int CNT_W = 16;

  logic             Hclk = 1'b0;
  logic             Hreset;
  logic             err_clr;
  logic             prot_err;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, err_cnt;

  apb_slave_regbank_if bus();

  apb_slave_regbank #(.SEL_INDEX(0), .DEPTH(16), .CNT_W(CNT_W)) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .bus      (bus),
    .err_clr  (err_clr),
    .prot_err (prot_err),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 Hclk = ~Hclk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ACCESS cycle of a read on our select line presents Prdata.
  always @(negedge Hclk) begin
    if (!Hreset && bus.Pselx[0] && bus.Penable && !bus.Pwrite) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.Prdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.Prdata !== e) begin
          fails++;
          $display("FAIL rd_data: got 0x%08h, expected 0x%08h", bus.Prdata, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Hclk); #1;
  endtask

  task automatic setup_ph(input logic [2:0] s, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.Pselx = s; bus.Penable = 1'b0; bus.Pwrite = w; bus.Paddr = a; bus.Pwdata = d;
    cyc();
  endtask

  task automatic access_ph();
    bus.Penable = 1'b1;
    cyc();
  endtask

  task automatic idle_ph();
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
    cyc();
  endtask

  task automatic wr_x(input logic [31:0] a, input logic [31:0] d);
    setup_ph(3'b001, 1'b1, a, d); access_ph(); idle_ph();
  endtask

  task automatic rd_x(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    setup_ph(3'b001, 1'b0, a, 32'h0); access_ph(); idle_ph();
  endtask

  task automatic chk_cnt(input string tag, input int w, input int r, input int e, input logic p);
    chk({tag, ".wr_cnt"},   32'(wr_cnt),   32'(w));
    chk({tag, ".rd_cnt"},   32'(rd_cnt),   32'(r));
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'(e));
    chk({tag, ".prot_err"}, 32'(prot_err), 32'(p));
  endtask

  initial begin
    Hreset = 1'b1; err_clr = 1'b0;
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = 32'h0; bus.Pwdata = 32'h0;
    cyc(); cyc();
    Hreset = 1'b0;
    cyc();
    chk_cnt("reset", 0, 0, 0, 1'b0);
    chk("reset.prdata", bus.Prdata, 32'h0);

    // write then read
    wr_x(32'h8000_0008, 32'hDEAD_BEEF);
    rd_x(32'h8000_0008, 32'hDEAD_BEEF);
    chk_cnt("wr_rd", 1, 1, 0, 1'b0);

    // back-to-back ACCESS -> SETUP
    setup_ph(3'b001, 1'b1, 32'h0C, 32'h11); access_ph();
    setup_ph(3'b001, 1'b1, 32'h10, 32'h22); access_ph();
    exp_q.push_back(32'h11);
    setup_ph(3'b001, 1'b0, 32'h0C, 32'h0); access_ph();
    exp_q.push_back(32'h22);
    setup_ph(3'b001, 1'b0, 32'h10, 32'h0); access_ph();
    idle_ph();
    chk_cnt("b2b", 3, 3, 0, 1'b0);

    // access without setup
    bus.Pselx = 3'b001; bus.Penable = 1'b1; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h14; bus.Pwdata = 32'h55;
    cyc();
    idle_ph();
    chk_cnt("nosetup", 3, 3, 1, 1'b1);
    rd_x(32'h14, 32'h0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
    chk_cnt("errclr", 3, 4, 1, 1'b0);

    // address changed between SETUP and ACCESS
    setup_ph(3'b001, 1'b1, 32'h08, 32'h77);
    bus.Paddr = 32'h14;
    access_ph();
    idle_ph();
    chk_cnt("addrchg", 3, 4, 2, 1'b1);
    rd_x(32'h08, 32'hDEAD_BEEF);
    rd_x(32'h14, 32'h0);
    wr_x(32'h14, 32'h5555_0005);
    rd_x(32'h14, 32'h5555_0005);
    chk_cnt("addrchg_after", 4, 7, 2, 1'b1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // aliasing, write does not disturb Prdata, deselected traffic
    wr_x(32'h40, 32'hA5A5_A5A5);
    rd_x(32'h00, 32'hA5A5_A5A5);
    wr_x(32'h00, 32'hFFFF_0000);
    chk("wr_keeps_prdata", bus.Prdata, 32'hA5A5_A5A5);
    setup_ph(3'b010, 1'b1, 32'h00, 32'h1234); access_ph(); idle_ph();
    setup_ph(3'b100, 1'b0, 32'h00, 32'h0);    access_ph(); idle_ph();
    bus.Pselx = 3'b010; bus.Penable = 1'b1; bus.Pwrite = 1'b1; cyc();
    idle_ph();
    chk_cnt("desel", 6, 8, 2, 1'b0);
    chk("desel.prdata", bus.Prdata, 32'hA5A5_A5A5);
    rd_x(32'h00, 32'hFFFF_0000);

    // reset during the SETUP cycle of a write
    setup_ph(3'b001, 1'b1, 32'h18, 32'h66);
    Hreset = 1'b1; bus.Penable = 1'b1;
    cyc();
    Hreset = 1'b0;
    idle_ph();
    chk_cnt("rst_mid", 0, 0, 0, 1'b0);
    chk("rst_mid.prdata", bus.Prdata, 32'h0);
    rd_x(32'h18, 32'h0);
    rd_x(32'h08, 32'h0);
    chk("rst_mid.rd_cnt2", 32'(rd_cnt), 32'd2);

    // err_clr in the same cycle as a violation
    bus.Pselx = 3'b001; bus.Penable = 1'b1; bus.Pwrite = 1'b1; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    idle_ph();
    chk_cnt("clr_vs_viol", 0, 2, 1, 1'b1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
    chk("clr_after.prot_err", 32'(prot_err), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
